// File: rtl/fir_pkg.sv
// Shared definitions for the fir filter chain: sample width and sample type.
package fir_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; the head entry is visible on dout while non-empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Keeps one fir output sample in every DECIM and buffers it for a ready/valid consumer,
// flagging kept samples lost to a full buffer.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int unsigned SAMPLE_W = fir_pkg::SAMPLE_W,
  parameter int unsigned DECIM    = 4,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SAMPLE_W-1:0] out_sample,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int unsigned PhaseW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PhaseW-1:0] PhaseMax = PhaseW'(DECIM - 1);

  if ((DECIM == 0) || (DECIM > 256)) begin : g_bad_decim
    $fatal(1, "fir_decimator: DECIM must be in 1..256");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "fir_decimator: DEPTH must be a power of two >= 2");
  end

  logic [PhaseW-1:0] phase_q, phase_d;
  logic              overflow_q, overflow_d;
  logic              keep, push, pop, drop;
  logic              fifo_full, fifo_empty;

  assign keep = in_valid && (phase_q == '0);
  assign pop  = out_valid && out_ready;
  assign push = keep && (!fifo_full || pop);
  assign drop = keep && fifo_full && !pop;

  always_comb begin
    phase_d    = phase_q;
    overflow_d = overflow_q;
    if (in_valid) begin
      phase_d = (phase_q == PhaseMax) ? '0 : phase_q + PhaseW'(1);
    end
    // A new drop outranks a clear arriving in the same cycle.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_sample),
    .dout  (out_sample),
    .count (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Drives a DECIM=4 and a DECIM=1 decimator with shared stimulus and compares both
// against queue-based reference models every cycle.
module tb_fir_decimator;
  import fir_pkg::*;

  localparam int unsigned Depth = 8;
  localparam int unsigned LvlW  = $clog2(Depth + 1);

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    in_valid = 1'b0;
  logic    out_ready = 1'b0;
  logic    ovf_clr = 1'b0;
  sample_t in_sample = '0;

  logic            out_valid4, out_valid1, overflow4, overflow1;
  sample_t         out_sample4, out_sample1;
  logic [LvlW-1:0] level4, level1;

  fir_decimator #(.SAMPLE_W(SAMPLE_W), .DECIM(4), .DEPTH(Depth)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid4),
    .out_ready  (out_ready),
    .out_sample (out_sample4),
    .level      (level4),
    .overflow   (overflow4),
    .ovf_clr    (ovf_clr)
  );

  fir_decimator #(.SAMPLE_W(SAMPLE_W), .DECIM(1), .DEPTH(Depth)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid1),
    .out_ready  (out_ready),
    .out_sample (out_sample1),
    .level      (level1),
    .overflow   (overflow1),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  int      n_tests = 0;
  int      n_fail  = 0;
  sample_t mq4[$];
  sample_t mq1[$];
  sample_t got4[$];
  sample_t got1[$];
  int      nv = 0;
  bit      movf4 = 1'b0;
  bit      movf1 = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit r, input bit iv, input sample_t s, input bit rdy,
                       input bit clr);
    sample_t e4, e1;
    bit      pop4, pop1, keep4, keep1, drop4, drop1;
    rst = r; in_valid = iv; in_sample = s; out_ready = rdy; ovf_clr = clr;
    if (r) begin
      mq4.delete(); mq1.delete(); nv = 0; movf4 = 1'b0; movf1 = 1'b0;
    end
    #1;
    e4 = (mq4.size() != 0) ? mq4[0] : '0;
    e1 = (mq1.size() != 0) ? mq1[0] : '0;
    check("valid4", out_valid4, mq4.size() != 0);
    check("sample4", out_sample4, e4);
    check("level4", level4, mq4.size());
    check("ovf4", overflow4, movf4);
    check("valid1", out_valid1, mq1.size() != 0);
    check("sample1", out_sample1, e1);
    check("level1", level1, mq1.size());
    check("ovf1", overflow1, movf1);
    if (out_valid4 && rdy) got4.push_back(out_sample4);
    if (out_valid1 && rdy) got1.push_back(out_sample1);
    if (!r) begin
      pop4  = (mq4.size() != 0) && rdy;
      pop1  = (mq1.size() != 0) && rdy;
      keep4 = iv && ((nv % 4) == 0);
      keep1 = iv;
      drop4 = keep4 && (mq4.size() == Depth) && !pop4;
      drop1 = keep1 && (mq1.size() == Depth) && !pop1;
      if (pop4) void'(mq4.pop_front());
      if (pop1) void'(mq1.pop_front());
      if (keep4 && !drop4) mq4.push_back(s);
      if (keep1 && !drop1) mq1.push_back(s);
      movf4 = drop4 ? 1'b1 : (clr ? 1'b0 : movf4);
      movf1 = drop1 ? 1'b1 : (clr ? 1'b0 : movf1);
      if (iv) nv++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int exp_dec[4];
    int exp_gap[2];
    int blk_p;

    // Reset state
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("rst_level4", level4, 0);
    check("rst_valid1", out_valid1, 0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Decimation order: 1..16 every cycle with DECIM=4
    exp_dec = '{1, 5, 9, 13};
    got4.delete();
    for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b1, sample_t'(i), 1'b1, 1'b0);
    idle(2, 1'b1);
    check("dec_count", got4.size(), 4);
    for (int k = 0; k < 4 && k < got4.size(); k++) check("dec_order", got4[k], exp_dec[k]);
    check("dec_ovf", overflow4, 0);

    // Gapped input: phase counts valid samples, not cycles
    do_reset();
    exp_gap = '{1, 5};
    got4.delete();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, sample_t'(i), 1'b1, 1'b0);
      idle(2, 1'b1);
    end
    idle(2, 1'b1);
    check("gap_count", got4.size(), 2);
    for (int k = 0; k < 2 && k < got4.size(); k++) check("gap_order", got4[k], exp_gap[k]);

    // Fill and overflow with DECIM=1
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, sample_t'(100 + i), 1'b0, 1'b0);
    check("fill_level", level1, 8);
    check("fill_ovf", overflow1, 1);
    got1.delete();
    idle(10, 1'b1);
    check("drain_count", got1.size(), 8);
    for (int k = 0; k < 8 && k < got1.size(); k++) check("drain_order", got1[k], 100 + k);

    // Full with simultaneous pop, then overflow clear priority
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, sample_t'(200 + i), 1'b0, 1'b0);
    got1.delete();
    cycle(1'b0, 1'b1, sample_t'(55), 1'b1, 1'b0);
    check("fullpop_level", level1, 8);
    check("fullpop_ovf", overflow1, 0);
    cycle(1'b0, 1'b1, sample_t'(66), 1'b0, 1'b0);
    check("drop_ovf", overflow1, 1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("clr_ovf", overflow1, 0);
    cycle(1'b0, 1'b1, sample_t'(67), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, sample_t'(68), 1'b0, 1'b1);
    check("set_wins_ovf", overflow1, 1);
    idle(10, 1'b1);
    check("fullpop_count", got1.size(), 9);
    if (got1.size() != 0) check("fullpop_last", got1[got1.size() - 1], 55);

    // Reset mid-stream: outputs clear before any clock edge
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, sample_t'(300 + i), 1'b0, 1'b0);
    check("pre_rst_level", level1, 5);
    rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid1, 0);
    check("rst_async_level", level1, 0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, sample_t'(77), 1'b1, 1'b0);
    check("post_rst_valid4", out_valid4, 1);
    check("post_rst_sample4", out_sample4, 77);
    check("post_rst_sample1", out_sample1, 77);
    idle(2, 1'b1);

    // Randomized traffic alternating light and heavy consumer stalls
    for (int blk = 0; blk < 8; blk++) begin
      blk_p = (blk % 2) ? 90 : 20;
      for (int i = 0; i < 50; i++) begin
        cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, sample_t'($urandom),
              $urandom_range(0, 99) < blk_p, $urandom_range(0, 15) == 0);
      end
    end
    idle(12, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
Downstream stage of the fir filter. Consumes the filter's in_valid/in_sample stream and keeps one sample in every DECIM. Kept samples are buffered in a small first-word-fall-through FIFO and delivered to the next consumer over a ready/valid handshake. The filter has no backpressure, so this block absorbs consumer stalls and flags lost samples.

Parameters:
SAMPLE_W, 16, width of signed input/output samples (matches the fir output width)
DECIM, 4, decimation factor; legal range 1..256
DEPTH, 8, FIFO depth in samples; power of two, at least 2

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  fir output sample valid (one-cycle strobe per sample)
in_sample  input  SAMPLE_W  signed fir output sample
out_valid  output  1  FIFO non-empty; head sample presented
out_ready  input  1  consumer accepts head sample when out_valid is high
out_sample  output  SAMPLE_W  signed head sample
level  output  $clog2(DEPTH+1)  current FIFO occupancy
overflow  output  1  sticky: a kept sample was dropped because the FIFO was full
ovf_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync release): phase=0, wr_ptr=0, rd_ptr=0, count=0, overflow=0. Outputs: out_valid=0, out_sample=0, level=0.
- Phase counter 0..DECIM-1. It advances only on in_valid and wraps from DECIM-1 to 0.
- Sample kept when in_valid && phase==0. The first sample after reset is always kept. DECIM=1 keeps every sample.
- Push = kept sample and (count<DEPTH or pop in same cycle).
- Pop = out_valid && out_ready.
- Full with simultaneous pop: the push is accepted and count is unchanged.
- Empty with simultaneous keep: the sample is written and out_valid rises next cycle. No same-cycle bypass.
- Latency: a kept sample at cycle N appears on out_sample with out_valid=1 at cycle N+1 if the FIFO was empty.
- out_valid = (count!=0). out_sample = mem[rd_ptr] when out_valid, else 0. level = count (registered).
- Kept sample while full and no pop: sample dropped, overflow set to 1 next cycle. The phase counter still advances.
- overflow stays set until ovf_clr or rst. If ovf_clr and a new drop occur in the same cycle, set wins.
- in_sample is ignored when in_valid=0. out_ready is ignored when out_valid=0.
- Pointers wrap modulo DEPTH. count is held in a separate register, so full and empty are unambiguous.
- Ordering is strict FIFO. No sample is duplicated or reordered.
- rst asserted mid-operation: all stored samples discarded immediately. out_valid drops asynchronously.
- Elaboration check: fatal error if DECIM<1, DECIM>256, or DEPTH is not a power of two ≥2.

Decomposition:
- Shared package fir_pkg:
  - SAMPLE_W constant (16)
  - sample_t typedef (logic signed [SAMPLE_W-1:0])
  - shared by fir, fir_decimator and benches
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - ports: push, pop, din, dout, count, full, empty
  - FWFT behaviour as above; reusable elsewhere in the filter chain
- fir_decimator top holds the phase counter, keep logic, overflow flag and FIFO instantiation.

Test Plan:
- Decimation order: DECIM=4, out_ready=1, in_valid every cycle with in_sample 1..16 → out_sample sequence 1,5,9,13, each out_valid one cycle after its input; overflow=0.
- Gapped input: DECIM=4, in_valid every 3rd cycle, samples 1..8 → outputs 1,5. Phase counts valid samples only, not cycles.
- Fill and overflow: DECIM=1, DEPTH=8, out_ready=0, push 10 samples (100..109) → level=8 and overflow=1 after sample 108. Then out_ready=1 drains exactly 100..107.
- Full with simultaneous pop: FIFO full, out_ready=1 in the same cycle as a kept sample 55 → level stays 8, overflow stays 0, and 55 emerges last.
- Clear priority: overflow=1, ovf_clr=1 on a cycle without a drop → overflow=0 next cycle. ovf_clr=1 on a drop cycle → overflow remains 1.
- Reset mid-stream: FIFO holding 5 samples, rst pulsed for 1 cycle → out_valid=0 and level=0 immediately. Next in_valid sample 77 is kept (phase=0) and appears on the following cycle.
